// File: rtl/cic_out_arbiter.sv
// cic_out_arbiter
// Collects one sample at a time from each of NUM_CH CIC decimator chains and
// feeds them, tagged with their channel number, into a single shared
// valid/ready stream in round-robin order. A channel that produces a new
// sample before its previous one was served keeps only the newest sample and
// raises a sticky overrun flag.

module cic_out_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int CHAN_WIDTH = 2,
    parameter int DATA_WIDTH = 20
) (
    input  logic                           clock,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              in_strobe,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CHAN_WIDTH-1:0]          out_chan,
    output logic [NUM_CH-1:0]              overrun,
    input  logic [NUM_CH-1:0]              overrun_clr
);

    // Per-channel holding registers and their "unserved sample" flags
    logic [DATA_WIDTH-1:0] hold [NUM_CH];
    logic [NUM_CH-1:0]     pending;

    // Channel granted most recently; the next search starts just after it
    logic [CHAN_WIDTH-1:0] last_grant;

    // Arbitration signals
    logic                  load_en;
    logic                  grant_en;
    logic [CHAN_WIDTH-1:0] start_ch;
    logic [NUM_CH-1:0]     rotated;
    int                    offset;
    int                    grant_int;
    logic [CHAN_WIDTH-1:0] grant_idx;
    logic [NUM_CH-1:0]     grant_vec;
    logic [DATA_WIDTH-1:0] sel_data;

    // The output register may take a new sample when empty or being drained
    assign load_en  = !out_valid || out_ready;
    assign grant_en = load_en && (|pending);

    // Round-robin search: rotate pending so the channel after last_grant sits at bit 0
    always_comb begin
        start_ch  = (last_grant == CHAN_WIDTH'(NUM_CH - 1)) ? '0 : last_grant + 1'b1;
        rotated   = NUM_CH'({pending, pending} >> start_ch);
        offset    = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = k;
            end
        end
        grant_int = (int'(start_ch) + offset) % NUM_CH;
        grant_idx = CHAN_WIDTH'(grant_int);
    end

    // One-hot grant and the matching sample, taken from the pre-capture holding register
    always_comb begin
        grant_vec = '0;
        sel_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_vec[c] = grant_en && (grant_idx == CHAN_WIDTH'(c));
            if (grant_vec[c]) begin
                sel_data = hold[c];
            end
        end
    end

    // Capture strobed samples; newest sample always replaces the held one
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hold[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_strobe[c]) begin
                    hold[c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Pending and overrun bookkeeping; a set event beats a clear in the same cycle
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= in_strobe | (pending & ~grant_vec);
            overrun <= (in_strobe & pending & ~grant_vec) | (overrun & ~overrun_clr);
        end
    end

    // Output register: load the granted sample or go idle when nothing is pending
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CHAN_WIDTH'(NUM_CH - 1);
        end else if (load_en) begin
            if (grant_en) begin
                out_valid  <= 1'b1;
                out_data   <= sel_data;
                out_chan   <= grant_idx;
                last_grant <= grant_idx;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
